// File: rtl/traffic_controller.sv
// Two-road traffic light sequencer driven by a 32-step phase counter.
// Optional pedestrian request/walk feature is enabled by defining TRAFFIC_PED_REQ_EN.

// state | meaning
// MG    | main green, side red      (counter 0-13)
// MY    | main yellow, side red     (counter 14-16)
// AR1   | all red                   (counter 17)
// SG    | main red, side green      (counter 18-25)
// SY    | main red, side yellow     (counter 26-28)
// AR2   | all red                   (counter 29-31)
module traffic_controller #(
  parameter logic [5:0] PED_JUMP = 6'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ped,
  output logic [5:0] counter,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk
);

  localparam logic [2:0] LAMP_G = 3'b001;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_R = 3'b100;

  typedef enum logic [2:0] {MG, MY, AR1, SG, SY, AR2} state_t;

  state_t     state, state_next;
  logic [5:0] counter_next;
  logic [2:0] main_next, side_next;
  logic       walk_next;

  function automatic state_t phase_of(input logic [5:0] c);
    state_t s;
    if (c <= 6'd13)      s = MG;
    else if (c <= 6'd16) s = MY;
    else if (c == 6'd17) s = AR1;
    else if (c <= 6'd25) s = SG;
    else if (c <= 6'd28) s = SY;
    else                 s = AR2;
    return s;
  endfunction

`ifdef TRAFFIC_PED_REQ_EN
  logic flag, flag_next;
  logic jump;

  // A request only shortens main green; late requests run the phase out normally.
  assign jump = (state == MG) && flag && (counter < (PED_JUMP - 6'd1));
`else
  logic unused_ped;
  localparam logic [5:0] unused_ped_jump = PED_JUMP;
  assign unused_ped = ped;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= MG;
      counter    <= '0;
      main_light <= LAMP_G;
      side_light <= LAMP_R;
      walk       <= 1'b0;
    end else begin
      state      <= state_next;
      counter    <= counter_next;
      main_light <= main_next;
      side_light <= side_next;
      walk       <= walk_next;
    end
  end

`ifdef TRAFFIC_PED_REQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) flag <= 1'b0;
    else     flag <= flag_next;
  end
`endif

  always_comb begin
    counter_next = counter;
    walk_next    = walk;
`ifdef TRAFFIC_PED_REQ_EN
    flag_next    = flag;
`endif

    if (tick) begin
`ifdef TRAFFIC_PED_REQ_EN
      if (jump)
        counter_next = PED_JUMP;
      else
`endif
      if (state == AR2 && counter == 6'd31)
        counter_next = '0;
      else
        counter_next = counter + 6'd1;
    end

    state_next = phase_of(counter_next);

`ifdef TRAFFIC_PED_REQ_EN
    if (tick && state_next == SG && state != SG) begin
      walk_next = flag;
      flag_next = 1'b0;
    end else if (state_next != SG) begin
      walk_next = 1'b0;
    end
    // A press in the clearing cycle must not be lost.
    if (ped)
      flag_next = 1'b1;
`else
    walk_next = 1'b0;
`endif

    main_next = LAMP_R;
    side_next = LAMP_R;
    case (state_next)
      MG:      begin main_next = LAMP_G; side_next = LAMP_R; end
      MY:      begin main_next = LAMP_Y; side_next = LAMP_R; end
      SG:      begin main_next = LAMP_R; side_next = LAMP_G; end
      SY:      begin main_next = LAMP_R; side_next = LAMP_Y; end
      default: begin main_next = LAMP_R; side_next = LAMP_R; end
    endcase
  end

endmodule

// File: tb/tb_traffic_controller.sv
// Scoreboard bench for traffic_controller: a phase-range reference model queues
// expected outputs per cycle and a monitor compares after each rising edge.
module tb_traffic_controller;

  localparam logic [5:0] PED_JUMP = 6'd9;

  logic       clk = 1'b0;
  logic       rst, tick, ped;
  logic [5:0] counter;
  logic [2:0] main_light, side_light;
  logic       walk;

  traffic_controller #(.PED_JUMP(PED_JUMP)) dut (
    .clk(clk), .rst(rst), .tick(tick), .ped(ped),
    .counter(counter), .main_light(main_light), .side_light(side_light), .walk(walk)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] cnt;
    logic [2:0] ml;
    logic [2:0] sl;
    logic       w;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int   m_cnt;
  bit   m_flag, m_walk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Lamp pair {main, side} from the phase ranges of the counter.
  function automatic logic [5:0] lamps(input int c);
    if (c <= 13)      return {3'b001, 3'b100};
    else if (c <= 16) return {3'b010, 3'b100};
    else if (c == 17) return {3'b100, 3'b100};
    else if (c <= 25) return {3'b100, 3'b001};
    else if (c <= 28) return {3'b100, 3'b010};
    else              return {3'b100, 3'b100};
  endfunction

  function automatic exp_t model_exp();
    exp_t e;
    logic [5:0] l;
    l     = lamps(m_cnt);
    e.cnt = 6'(m_cnt);
    e.ml  = l[5:3];
    e.sl  = l[2:0];
    e.w   = m_walk;
    return e;
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_flag = 1'b0;
    m_walk = 1'b0;
  endtask

  task automatic model_step(input bit t, input bit p);
    int  nc;
    bit  nflag;
    nc    = m_cnt;
    nflag = m_flag;
    if (t) begin
`ifdef TRAFFIC_PED_REQ_EN
      if (m_cnt <= 13 && m_flag && m_cnt < int'(PED_JUMP) - 1) nc = int'(PED_JUMP);
      else nc = (m_cnt + 1) % 32;
      if (nc == 18 && m_cnt != 18) begin
        m_walk = m_flag;
        nflag  = 1'b0;
      end else if (nc < 18 || nc > 25) begin
        m_walk = 1'b0;
      end
`else
      nc = (m_cnt + 1) % 32;
`endif
    end
`ifdef TRAFFIC_PED_REQ_EN
    if (p) nflag = 1'b1;
`endif
    m_cnt  = nc;
    m_flag = nflag;
  endtask

  task automatic cycle(input bit t, input bit p);
    @(negedge clk);
    tick = t;
    ped  = p;
    model_step(t, p);
    sb.push_back(model_exp());
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 100 && m_cnt != target; i++) cycle(1'b1, 1'b0);
    if (m_cnt != target) begin
      checks++;
      errors++;
      $display("FAIL run_to: model counter %0d expected %0d", m_cnt, target);
    end
  endtask

  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (!rst && sb.size() > 0) begin
      e = sb.pop_front();
      check("counter", int'(counter), int'(e.cnt));
      check("main_light", int'(main_light), int'(e.ml));
      check("side_light", int'(side_light), int'(e.sl));
      check("walk", int'(walk), int'(e.w));
    end
  end

  initial begin
    rst  = 1'b1;
    tick = 1'b0;
    ped  = 1'b0;
    model_reset();
    #1;
    check("reset_counter", int'(counter), 0);
    check("reset_main", int'(main_light), 1);
    check("reset_side", int'(side_light), 4);
    check("reset_walk", int'(walk), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // full cycle with no requests, including the 31 -> 0 wrap
    for (int i = 0; i < 33; i++) cycle(1'b1, 1'b0);

    // early request: jump from 3 to PED_JUMP, walk through SG
    run_to(3);
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0);
    run_to(27);

    // late request: no jump, walk still served
    run_to(12);
    cycle(1'b0, 1'b1);
    run_to(27);

    // request during SG is held until the next main green
    run_to(20);
    cycle(1'b0, 1'b1);
    run_to(0);
    cycle(1'b1, 1'b0);
    run_to(27);

    // randomized ticks and presses, including simultaneous ped/tick
    for (int i = 0; i < 800; i++)
      cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));

    // asynchronous reset mid-SG, checked between edges
    run_to(22);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_counter", int'(counter), 0);
    check("async_main", int'(main_light), 1);
    check("async_side", int'(side_light), 4);
    check("async_walk", int'(walk), 0);
    model_reset();
    sb.delete();
    @(negedge clk);
    tick = 1'b0;
    ped  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 1'b0);

    // ped held high across two full cycles
    for (int i = 0; i < 64; i++) cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b0);

    @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_controller.md
TRAFFIC_CONTROLLER -- requirements
Module: traffic_controller

Interface
REQ-001 Parameter PED_JUMP, default 6'd9: counter value main green jumps to on a pending pedestrian request.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 tick  input  1  advance strobe; counter/FSM move only in cycles with tick=1.
REQ-005 ped  input  1  pedestrian button, level, sampled every clk.
REQ-006 counter  output  6  phase counter, range 0..31; feeds downstream enable decode.
REQ-007 main_light  output  3  main-road lamps {red,yellow,green}, one-hot.
REQ-008 side_light  output  3  side-road lamps {red,yellow,green}, one-hot.
REQ-009 walk  output  1  pedestrian walk lamp.

Function
REQ-010 Lamp encoding SHALL be green=3'b001, yellow=3'b010, red=3'b100; no other value ever driven.
REQ-011 FSM states SHALL be MG, MY, AR1, SG, SY, AR2, derived from counter: MG 0-13, MY 14-16, AR1 17, SG 18-25, SY 26-28, AR2 29-31.
REQ-012 Lamps per state: MG main=G side=R; MY main=Y side=R; AR1 both R; SG main=R side=G; SY main=R side=Y; AR2 both R.
REQ-013 On tick=1 counter SHALL increment by 1; 31 SHALL wrap to 0 (MG) in the same tick; tick=0 holds all state.
REQ-014 counter, lamps and walk SHALL be registered outputs, updating the cycle after the tick that advances them (one-clk latency).
REQ-015 Lamps SHALL always be consistent with the registered counter per REQ-011/012 (no cycle of mismatch).
REQ-016 ped=1 in any cycle SHALL set a pending-request flag; flag stays set until cleared per REQ-018.
REQ-017 On tick=1 in MG with flag set and counter < PED_JUMP-1, counter SHALL load PED_JUMP instead of incrementing; counter >= PED_JUMP-1 increments normally.
REQ-018 On the tick entering SG with flag set, walk SHALL assert and the flag SHALL clear in the same cycle.
REQ-019 walk SHALL deassert on the tick entering SY and be 0 in all non-SG states.
REQ-020 ped=1 in the same cycle the flag clears SHALL leave the flag set (set wins).
REQ-021 Requests during SG/SY/AR2 SHALL be held and serviced in the next MG.
REQ-022 Simultaneous ped and tick SHALL be honoured: flag set this cycle, affects the next tick only.

Reset
REQ-023 rst=1 SHALL immediately (asynchronously) force counter=0, state MG, main_light=3'b001, side_light=3'b100, walk=0, flag=0.
REQ-024 Reset mid-phase SHALL abandon the phase; first tick after release advances counter 0->1.

Configuration
REQ-025 Macro TRAFFIC_PED_REQ_EN SHALL gate the pedestrian feature.
REQ-026 Defined: REQ-016..REQ-022 apply.
REQ-027 Undefined: ped ignored, no flag logic, walk tied 0, counter strictly increments 0..31 with wrap; port list unchanged.

Verification
REQ-028 Reset then 32 ticks, ped=0 -> counter 0..31 then 0; lamps per REQ-012 at each value; walk=0 throughout.
REQ-029 Pulse ped at counter=3 (MG), then tick -> counter=9; at counter 18 walk=1, side=001; at 26 walk=0, side=010.
REQ-030 Pulse ped at counter=12 -> counter continues 13,14 (no jump); walk=1 at 18.
REQ-031 Pulse ped at counter=20 (SG) -> walk stays 0 this SG; next MG jumps at counter 0 -> 9; walk=1 at next 18.
REQ-032 Assert rst asynchronously at counter=22 between clk edges -> counter=0, main=001, side=100, walk=0 before next edge.
REQ-033 Build without TRAFFIC_PED_REQ_EN, ped held 1 for 64 ticks -> no jumps, walk=0, sequence identical to REQ-028.
